// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud timing and MMIO map.
// The MMIO-driven transmitter imports this package as well.
package uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // 27 MHz core clock at 115200 baud
   localparam int DEFAULT_DELAY_FRAMES = 234;

   localparam logic [15:0] TX_DATA_ADDR   = 16'hf001;
   localparam logic [15:0] RX_DATA_ADDR   = 16'hf002;
   localparam logic [15:0] RX_STATUS_ADDR = 16'hf003;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received data; head is visible combinationally while non-empty.
// A push on a full FIFO is accepted only when an effective pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a small FIFO, read by the CPU through a data and a status address.
// Reads complete in one clock; frame_error and overrun are sticky until a status read.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int          DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] DATA_ADDR    = RX_DATA_ADDR,
   parameter logic [15:0] STATUS_ADDR  = RX_STATUS_ADDR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   input  logic [15:0] mmio_addr,
   input  logic        mmio_read,
   output logic [7:0]  mmio_rdata,
   output logic        rx_ready,
   output logic        frame_error,
   output logic        overrun
);

   localparam logic [15:0] FULL_BIT = 16'(DELAY_FRAMES);
   localparam logic [15:0] HALF_BIT = 16'(DELAY_FRAMES / 2);
   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

   logic            rx_meta;
   logic            rx_s;
   rx_state_t       state;
   rx_state_t       state_next;
   logic [15:0]     cnt;
   logic [15:0]     cnt_next;
   logic [15:0]     cnt_inc;
   logic [2:0]      bit_num;
   logic [2:0]      bit_next;
   logic [7:0]      shift;
   logic [7:0]      shift_next;
   logic            push;
   logic            frame_set;
   logic            overrun_set;
   logic            data_rd;
   logic            status_rd;
   logic [7:0]      head;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_num <= '0;
         shift   <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_num <= bit_next;
         shift   <= shift_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_num;
      shift_next = shift;
      push       = 1'b0;
      frame_set  = 1'b0;
      cnt_inc    = cnt + 16'd1;
      unique case (state)
         RX_IDLE: begin
            cnt_next = '0;
            if (!rx_s) state_next = RX_START;
         end
         RX_START: begin
            cnt_next = cnt_inc;
            if (cnt_inc == HALF_BIT) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next = RX_DATA;
                  bit_next   = '0;
               end else begin
                  state_next = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            cnt_next = cnt_inc;
            if (cnt_inc == FULL_BIT) begin
               cnt_next            = '0;
               shift_next[bit_num] = rx_s;
               if (bit_num == 3'd7) state_next = RX_STOP;
               else                 bit_next   = bit_num + 3'd1;
            end
         end
         RX_STOP: begin
            cnt_next = cnt_inc;
            if (cnt_inc == FULL_BIT) begin
               cnt_next   = '0;
               state_next = RX_IDLE;
               if (rx_s) push      = 1'b1;
               else      frame_set = 1'b1;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   assign data_rd   = mmio_read && (mmio_addr == DATA_ADDR);
   assign status_rd = mmio_read && (mmio_addr == STATUS_ADDR);
   // a full FIFO is never empty, so a data read here always frees a slot
   assign overrun_set = push && full && !data_rd;
   assign rx_ready    = (count != '0);

   uart_rx_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (shift),
      .pop       (data_rd),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mmio_rdata  <= '0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (data_rd)        mmio_rdata <= empty ? 8'h00 : head;
         else if (status_rd) mmio_rdata <= {5'b0, overrun, frame_error, rx_ready};
         frame_error <= frame_set | (frame_error & ~status_rd);
         overrun     <= overrun_set | (overrun & ~status_rd);
      end
   end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio with a short bit period and a 4-entry FIFO.
module tb_uart_rx_mmio;

   localparam int          D     = 16;
   localparam logic [15:0] DADDR = 16'hf002;
   localparam logic [15:0] SADDR = 16'hf003;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic [15:0] mmio_addr = 16'h0000;
   logic        mmio_read = 1'b0;
   logic [7:0]  mmio_rdata;
   logic        rx_ready;
   logic        frame_error;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   uart_rx_mmio #(
      .DELAY_FRAMES(D),
      .FIFO_DEPTH  (4),
      .DATA_ADDR   (DADDR),
      .STATUS_ADDR (SADDR)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .mmio_addr   (mmio_addr),
      .mmio_read   (mmio_read),
      .mmio_rdata  (mmio_rdata),
      .rx_ready    (rx_ready),
      .frame_error (frame_error),
      .overrun     (overrun)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // All tasks start and end on a falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (D) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (D) @(negedge clock);
      end
      rx = stop_bit;
      repeat (D) @(negedge clock);
      rx = 1'b1;
      repeat (D) @(negedge clock);
   endtask

   task automatic mmio_rd(input logic [15:0] a, output logic [7:0] d);
      mmio_addr = a;
      mmio_read = 1'b1;
      @(negedge clock);
      mmio_read = 1'b0;
      mmio_addr = 16'h0000;
      d = mmio_rdata;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock);
      checks++; if (mmio_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", mmio_rdata); end
      checks++; if ({rx_ready, frame_error, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rx_ready, frame_error, overrun}); end
      reset = 1'b0;
      repeat (2 * D) @(negedge clock);
   endtask

   task automatic test_basic_rx;
      logic [7:0] d;
      send_frame(8'hA3, 1'b1);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL a3_rx_ready: got %b expected 1", rx_ready); end
      mmio_rd(DADDR, d);
      checks++; if (d !== 8'hA3) begin errors++; $display("FAIL a3_data: got %h expected a3", d); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL a3_ready_after_pop: got %b expected 0", rx_ready); end
      mmio_rd(16'hf001, d);
      checks++; if (d !== 8'hA3) begin errors++; $display("FAIL other_addr_hold: got %h expected a3", d); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL a3_status: got %h expected 00", d); end
   endtask

   task automatic test_glitch;
      logic [7:0] d;
      rx = 1'b0;
      repeat (4) @(negedge clock);
      rx = 1'b1;
      repeat (2 * D) @(negedge clock);
      checks++; if ({rx_ready, frame_error} !== 2'b00) begin errors++; $display("FAIL glitch_no_push: got %b expected 00", {rx_ready, frame_error}); end
      send_frame(8'h55, 1'b1);
      mmio_rd(DADDR, d);
      checks++; if (d !== 8'h55) begin errors++; $display("FAIL glitch_then_55: got %h expected 55", d); end
   endtask

   task automatic test_frame_error;
      logic [7:0] d;
      send_frame(8'h3C, 1'b0);
      repeat (2 * D) @(negedge clock);
      checks++; if ({rx_ready, frame_error} !== 2'b01) begin errors++; $display("FAIL ferr_flags: got %b expected 01", {rx_ready, frame_error}); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL ferr_status1: got %h expected 02", d); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL ferr_status2: got %h expected 00", d); end
   endtask

   task automatic test_overrun;
      logic [7:0] d;
      logic [7:0] exp_q [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      checks++; if ({rx_ready, overrun} !== 2'b11) begin errors++; $display("FAIL ovr_flags: got %b expected 11", {rx_ready, overrun}); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL ovr_status: got %h expected 05", d); end
      for (int i = 0; i < 5; i++) begin
         mmio_rd(DADDR, d);
         checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL ovr_read%0d: got %h expected %h", i, d, exp_q[i]); end
      end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b expected 0", overrun); end
   endtask

   // Fifth push lands 155 rising edges after the start bit is driven;
   // the read strobe is placed in exactly that cycle.
   task automatic test_back_to_back;
      logic [7:0] d;
      logic [7:0] d_sim;
      logic [7:0] exp_q [4] = '{8'h20, 8'h30, 8'h40, 8'h50};
      send_frame(8'h10, 1'b1);
      send_frame(8'h20, 1'b1);
      send_frame(8'h30, 1'b1);
      send_frame(8'h40, 1'b1);
      fork
         send_frame(8'h50, 1'b1);
         begin
            repeat (154) @(negedge clock);
            mmio_rd(DADDR, d_sim);
         end
      join
      checks++; if (d_sim !== 8'h10) begin errors++; $display("FAIL b2b_sim_pop: got %h expected 10", d_sim); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL b2b_status: got %h expected 01", d); end
      for (int i = 0; i < 4; i++) begin
         mmio_rd(DADDR, d);
         checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL b2b_read%0d: got %h expected %h", i, d, exp_q[i]); end
      end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", rx_ready); end
   endtask

   task automatic test_mid_frame_reset;
      logic [7:0] d;
      send_frame(8'h42, 1'b1);
      send_frame(8'h3C, 1'b0);
      checks++; if ({rx_ready, frame_error, mmio_rdata} !== {2'b11, 8'h50}) begin errors++; $display("FAIL rst_pre: got %b/%b/%h expected 1/1/50", rx_ready, frame_error, mmio_rdata); end
      rx = 1'b0;
      repeat (D) @(negedge clock);
      rx = 1'b1;
      repeat (40) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++; if ({rx_ready, frame_error, overrun, mmio_rdata} !== 11'h000) begin errors++; $display("FAIL rst_mid: got %b%b%b/%h expected 000/00", rx_ready, frame_error, overrun, mmio_rdata); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3 * D) @(negedge clock);
      checks++; if ({rx_ready, frame_error} !== 2'b00) begin errors++; $display("FAIL rst_idle_after: got %b expected 00", {rx_ready, frame_error}); end
      mmio_rd(DADDR, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_fifo_empty: got %h expected 00", d); end
      send_frame(8'h81, 1'b1);
      mmio_rd(DADDR, d);
      checks++; if (d !== 8'h81) begin errors++; $display("FAIL rst_then_81: got %h expected 81", d); end
      mmio_rd(SADDR, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_final_status: got %h expected 00", d); end
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_basic_rx();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_back_to_back();
      test_mid_frame_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
